fc1_ifm_streamer: RTL

Producer-side driver of the fully-connected layer 1 input handshake. It collects one 120-word input feature vector from the upstream conv/flatten stage into a local frame buffer, then streams it into FC1's IFM memory with a write-enable burst and fires the start pulse. It tracks FC1 busy/done through the end handshake so the next frame loads only after FC1 has released its IFM. Sits between the last conv/pool stage and the FC1 top.

---
 rtl/fc1_ifm_streamer_if.sv | 46 ++++
 rtl/fc1_ifm_streamer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fc1_ifm_streamer_if.sv
// ---------------------------------------------------------------------------
// fc1_ifm_streamer_if
// Bundles the upstream word stream and the FC1 IFM load handshake of
// fc1_ifm_streamer.
//   in_valid / in_data / in_last / in_ready : upstream feature words
//   data_in_from_previous                   : word written into FC1 IFM
//   ifm_enable_write_previous               : FC1 IFM write strobe
//   start_from_previous                     : FC1 start pulse
//   end_to_previous                         : FC1 done pulse (IFM released)
// slave  : streamer side (accepts words, drives FC1 load)
// master : environment side (upstream producer + FC1)
// ---------------------------------------------------------------------------
interface fc1_ifm_streamer_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_in_from_previous;
    logic                  ifm_enable_write_previous;
    logic                  start_from_previous;
    logic                  end_to_previous;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output data_in_from_previous,
        output ifm_enable_write_previous,
        output start_from_previous,
        input  end_to_previous
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  data_in_from_previous,
        input  ifm_enable_write_previous,
        input  start_from_previous,
        output end_to_previous
    );
endinterface

// File: rtl/fc1_ifm_streamer.sv
// ---------------------------------------------------------------------------
// fc1_ifm_streamer
// Collects one IFM_DEPTH-word feature vector from the upstream stage into a
// local frame buffer, bursts it into FC1's IFM memory (one word per strobe
// cycle, ascending address, no gaps), then fires a one-cycle start pulse.
// FC1 ownership (fc_busy) is held from the start pulse until FC1 returns
// end_to_previous; only the burst waits on it, so the next fill overlaps
// FC1 compute.
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-low reset
//   bus           fc1_ifm_streamer_if.slave (upstream stream + FC1 load)
//   fc_busy       FC1 currently holds a frame from this block
//   frame_error   sticky: in_last disagreed with the word count
//   frames_sent   number of start pulses issued (wraps)
// ---------------------------------------------------------------------------
module fc1_ifm_streamer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IFM_DEPTH  = 120,
    parameter int unsigned ADDR_W     = $clog2(IFM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    fc1_ifm_streamer_if.slave      bus,
    output logic                   fc_busy,
    output logic                   frame_error,
    output logic [15:0]            frames_sent
);

    localparam int unsigned       CNT_W    = 16;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IFM_DEPTH - 1);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        WAIT_FC = 2'd1,
        SEND    = 2'd2,
        START   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_d;
    logic [ADDR_W-1:0]     wr_cnt;
    logic [ADDR_W-1:0]     wr_cnt_d;
    logic [ADDR_W-1:0]     rd_cnt;
    logic [ADDR_W-1:0]     rd_cnt_d;

    logic                  in_ready_q;
    logic                  in_ready_d;
    logic                  strobe_q;
    logic                  start_q;
    logic                  start_d;
    logic                  busy_d;
    logic                  err_d;
    logic [CNT_W-1:0]      frames_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  accept_c;
    logic                  wr_en_c;
    logic                  rd_en_c;

    // Frame buffer: one write port (fill), one registered read port (send)
    logic [DATA_WIDTH-1:0] mem [IFM_DEPTH];

    assign accept_c = bus.in_valid && in_ready_q;

    // Next-state, counters and registered-output next values
    always_comb begin
        state_d    = state;
        wr_cnt_d   = wr_cnt;
        rd_cnt_d   = rd_cnt;
        wr_en_c    = 1'b0;
        rd_en_c    = 1'b0;
        start_d    = 1'b0;
        busy_d     = fc_busy;
        err_d      = frame_error;
        frames_d   = frames_sent;

        // An end pulse coinciding with our start pulse cannot refer to the
        // frame just handed over, so it never clears ownership.
        if (fc_busy && bus.end_to_previous && !start_q) begin
            busy_d = 1'b0;
        end

        unique case (state)
            FILL: begin
                if (accept_c) begin
                    wr_en_c = 1'b1;
                    // Frame boundary follows the count; in_last only flags errors
                    if (wr_cnt == LAST_IDX) begin
                        wr_cnt_d = '0;
                        state_d  = WAIT_FC;
                        if (!bus.in_last) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        wr_cnt_d = wr_cnt + ADDR_W'(1);
                        if (bus.in_last) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            WAIT_FC: begin
                // Leave as soon as FC1 releases, including the release cycle itself
                if (!fc_busy || (bus.end_to_previous && !start_q)) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                rd_en_c = 1'b1;
                if (rd_cnt == LAST_IDX) begin
                    rd_cnt_d = '0;
                    state_d  = START;
                end else begin
                    rd_cnt_d = rd_cnt + ADDR_W'(1);
                end
            end
            START: begin
                start_d  = 1'b1;
                busy_d   = 1'b1;
                frames_d = frames_sent + CNT_W'(1);
                state_d  = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase

        // Upstream reopens one cycle after the start pulse
        in_ready_d = (state_d == FILL) && (state != START);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= FILL;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            in_ready_q  <= 1'b0;
            strobe_q    <= 1'b0;
            start_q     <= 1'b0;
            fc_busy     <= 1'b0;
            frame_error <= 1'b0;
            frames_sent <= '0;
            rd_data_q   <= '0;
        end else begin
            state       <= state_d;
            wr_cnt      <= wr_cnt_d;
            rd_cnt      <= rd_cnt_d;
            in_ready_q  <= in_ready_d;
            strobe_q    <= rd_en_c;
            start_q     <= start_d;
            fc_busy     <= busy_d;
            frame_error <= err_d;
            frames_sent <= frames_d;
            // Read register doubles as the IFM data output; holds between bursts
            if (rd_en_c) begin
                rd_data_q <= mem[rd_cnt];
            end
        end
    end

    // Buffer write port (contents need no reset)
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_cnt] <= bus.in_data;
        end
    end

    assign bus.in_ready                  = in_ready_q;
    assign bus.data_in_from_previous     = rd_data_q;
    assign bus.ifm_enable_write_previous = strobe_q;
    assign bus.start_from_previous       = start_q;

endmodule
